// File: rtl/trv_lsu_if.sv
// Signal bundle between the LSU and its neighbours: upstream operation, memory port, writeback.
// The slave modport is the LSU's view; the master modport is the surrounding pipeline.
interface trv_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_store;
  logic [2:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd_idx;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd_idx;
  logic        out_wen;
  logic        out_exc;

  modport master (
    output in_valid, in_store, in_op, in_addr, in_wdata, in_rd_idx,
    output mem_ack, mem_rdata, out_ready,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  out_valid, out_data, out_rd_idx, out_wen, out_exc
  );

  modport slave (
    input  in_valid, in_store, in_op, in_addr, in_wdata, in_rd_idx,
    input  mem_ack, mem_rdata, out_ready,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output out_valid, out_data, out_rd_idx, out_wen, out_exc
  );
endinterface

// File: rtl/trv_lsu.sv
// Memory-stage load/store unit: one word-aligned req/ack access per operation, then load
// alignment and extension, with misaligned/illegal operations turned into an exception result.
module trv_lsu (
  input logic       clk,
  input logic       rst,
  trv_lsu_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_rd_idx_q, out_rd_idx_d;
  logic        out_wen_q, out_wen_d;
  logic        out_exc_q, out_exc_d;

  logic [1:0]  off;
  logic        is_half, is_word, illegal, misalign, exc;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign off = bus.in_addr[1:0];

  // Operation decode and store-lane formatting for the incoming request.
  always_comb begin
    is_half  = (bus.in_op[1:0] == 2'b01);
    is_word  = bus.in_op[1];
    illegal  = bus.in_store ? bus.in_op[2]
                            : ((bus.in_op == 3'b011) || (bus.in_op[2:1] == 2'b11));
    misalign = (is_half && off[0]) || (is_word && (off != 2'b00));
    exc      = illegal || misalign;
    case (bus.in_op[1:0])
      2'b00: begin
        fmt_be    = 4'b0001 << off;
        fmt_wdata = {4{bus.in_wdata[7:0]}};
      end
      2'b01: begin
        fmt_be    = 4'b0011 << off;
        fmt_wdata = {2{bus.in_wdata[15:0]}};
      end
      default: begin
        fmt_be    = 4'b1111;
        fmt_wdata = bus.in_wdata;
      end
    endcase
  end

  always_comb begin
    shifted = bus.mem_rdata >> {off_q, 3'b000};
    case (op_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = shifted;
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    op_d         = op_q;
    off_d        = off_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_rd_idx_d = out_rd_idx_q;
    out_wen_d    = out_wen_q;
    out_exc_d    = out_exc_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          mem_we_d     = bus.in_store;
          mem_addr_d   = {bus.in_addr[31:2], 2'b00};
          mem_wdata_d  = fmt_wdata;
          mem_be_d     = fmt_be;
          op_d         = bus.in_op;
          off_d        = off;
          out_rd_idx_d = bus.in_rd_idx;
          if (exc) begin
            // Faulting ops skip the memory port and report immediately.
            out_valid_d = 1'b1;
            out_exc_d   = 1'b1;
            out_wen_d   = 1'b0;
            out_data_d  = 32'd0;
            state_d     = StResp;
          end else begin
            mem_req_d = 1'b1;
            out_exc_d = 1'b0;
            state_d   = StReq;
          end
        end
      end
      StReq: begin
        if (bus.mem_ack) begin
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          out_wen_d   = ~mem_we_q;
          out_data_d  = mem_we_q ? 32'd0 : load_data;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_be_q     <= 4'd0;
      op_q         <= 3'd0;
      off_q        <= 2'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'd0;
      out_rd_idx_q <= 5'd0;
      out_wen_q    <= 1'b0;
      out_exc_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      op_q         <= op_d;
      off_q        <= off_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_rd_idx_q <= out_rd_idx_d;
      out_wen_q    <= out_wen_d;
      out_exc_q    <= out_exc_d;
    end
  end

  assign bus.in_ready   = (state_q == StIdle) && !rst;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_rd_idx = out_rd_idx_q;
  assign bus.out_wen    = out_wen_q;
  assign bus.out_exc    = out_exc_q;

endmodule

// File: tb/tb_trv_lsu.sv
// Directed bench for trv_lsu: loads, stores, exceptions, backpressure and mid-operation reset.
module tb_trv_lsu;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  trv_lsu_if bus ();

  trv_lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: accept, optional memory phase, writeback with backpressure.
  task automatic xact(input string tag, input logic st, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                      input logic [31:0] rdata, input int ack_dly, input int rdy_dly,
                      input logic exp_exc, input logic [31:0] exp_addr,
                      input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                      input logic [31:0] exp_data);
    for (int k = 0; k < 20 && !bus.in_ready; k++) step();
    check({tag, ".accept_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_store  = st;
    bus.in_op     = op;
    bus.in_addr   = addr;
    bus.in_wdata  = wdata;
    bus.in_rd_idx = rd;
    step();
    bus.in_valid  = 1'b0;
    bus.in_addr   = 32'hFFFF_FFFF;
    bus.in_wdata  = 32'h5555_5555;
    bus.in_rd_idx = 5'd0;
    if (!exp_exc) begin
      for (int i = 0; i <= ack_dly; i++) begin
        bus.mem_ack   = (i == ack_dly);
        bus.mem_rdata = (i == ack_dly) ? rdata : 32'h0BAD_0BAD;
        @(negedge clk);
        check({tag, ".req"}, {31'd0, bus.mem_req}, 32'd1);
        check({tag, ".we"}, {31'd0, bus.mem_we}, {31'd0, st});
        check({tag, ".addr"}, bus.mem_addr, exp_addr);
        check({tag, ".be"}, {28'd0, bus.mem_be}, {28'd0, exp_be});
        if (st) check({tag, ".wdata"}, bus.mem_wdata, exp_wdata);
        check({tag, ".busy_valid"}, {31'd0, bus.out_valid}, 32'd0);
        step();
      end
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
    end
    for (int j = 0; j <= rdy_dly; j++) begin
      bus.out_ready = (j == rdy_dly);
      @(negedge clk);
      check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({tag, ".data"}, bus.out_data, exp_data);
      check({tag, ".exc"}, {31'd0, bus.out_exc}, {31'd0, exp_exc});
      check({tag, ".wen"}, {31'd0, bus.out_wen}, {31'd0, !st && !exp_exc});
      check({tag, ".rd"}, {27'd0, bus.out_rd_idx}, {27'd0, rd});
      check({tag, ".resp_req"}, {31'd0, bus.mem_req}, 32'd0);
      check({tag, ".resp_ready"}, {31'd0, bus.in_ready}, 32'd0);
      step();
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, ".done_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, ".done_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_store  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_addr   = 32'd0;
    bus.in_wdata  = 32'd0;
    bus.in_rd_idx = 5'd0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst.in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst.mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst.mem_addr", bus.mem_addr, 32'd0);
    check("rst.mem_be", {28'd0, bus.mem_be}, 32'd0);
    check("rst.out_data", bus.out_data, 32'd0);
    check("rst.out_flags", {29'd0, bus.mem_we, bus.out_wen, bus.out_exc}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst.ready_after", {31'd0, bus.in_ready}, 32'd1);
    step();

    //    tag    st    op      addr          wdata         rd     rdata         ack rdy exc
    xact("lw",   1'b0, 3'b010, 32'h0000_0100, 32'h0,        5'd1,  32'hDEAD_BEEF, 0, 0, 1'b0,
         32'h0000_0100, 32'h0, 4'b1111, 32'hDEAD_BEEF);
    xact("lb",   1'b0, 3'b000, 32'h0000_0203, 32'h0,        5'd2,  32'h80FF_1234, 0, 0, 1'b0,
         32'h0000_0200, 32'h0, 4'b1000, 32'hFFFF_FF80);
    xact("lbu",  1'b0, 3'b100, 32'h0000_0203, 32'h0,        5'd3,  32'h80FF_1234, 1, 0, 1'b0,
         32'h0000_0200, 32'h0, 4'b1000, 32'h0000_0080);
    xact("sh",   1'b1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 5'd4,  32'h0,        3, 0, 1'b0,
         32'h0000_0010, 32'hABCD_ABCD, 4'b1100, 32'h0);
    xact("lwmis", 1'b0, 3'b010, 32'h0000_0102, 32'h0,       5'd5,  32'h0,        0, 0, 1'b1,
         32'h0, 32'h0, 4'b0000, 32'h0);
    xact("still", 1'b1, 3'b100, 32'h0000_0040, 32'h1234,    5'd6,  32'h0,        0, 1, 1'b1,
         32'h0, 32'h0, 4'b0000, 32'h0);
    xact("lh",   1'b0, 3'b001, 32'h0000_0006, 32'h0,        5'd7,  32'h8001_0000, 0, 5, 1'b0,
         32'h0000_0004, 32'h0, 4'b1100, 32'hFFFF_8001);
    xact("sb",   1'b1, 3'b000, 32'h0000_0041, 32'h1234_56A5, 5'd8, 32'h0,        1, 2, 1'b0,
         32'h0000_0040, 32'hA5A5_A5A5, 4'b0010, 32'h0);
    xact("lhu",  1'b0, 3'b101, 32'h0000_0002, 32'h0,        5'd9,  32'h8001_0000, 0, 0, 1'b0,
         32'h0000_0000, 32'h0, 4'b1100, 32'h0000_8001);
    xact("ldill", 1'b0, 3'b011, 32'h0000_0000, 32'h0,       5'd10, 32'h0,        0, 0, 1'b1,
         32'h0, 32'h0, 4'b0000, 32'h0);
    xact("lhmis", 1'b0, 3'b001, 32'h0000_0005, 32'h0,       5'd11, 32'h0,        0, 0, 1'b1,
         32'h0, 32'h0, 4'b0000, 32'h0);
    xact("sw",   1'b1, 3'b010, 32'h0000_0080, 32'hCAFE_F00D, 5'd12, 32'h0,        2, 0, 1'b0,
         32'h0000_0080, 32'hCAFE_F00D, 4'b1111, 32'h0);

    // Reset while a load waits in REQ; a late ack must not produce a result.
    step();
    bus.in_valid  = 1'b1;
    bus.in_store  = 1'b0;
    bus.in_op     = 3'b010;
    bus.in_addr   = 32'h0000_0300;
    bus.in_rd_idx = 5'd13;
    step();
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("mrst.req_before", {31'd0, bus.mem_req}, 32'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("mrst.ready_in_rst", {31'd0, bus.in_ready}, 32'd0);
    step();
    rst           = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    @(negedge clk);
    check("mrst.req", {31'd0, bus.mem_req}, 32'd0);
    check("mrst.addr", bus.mem_addr, 32'd0);
    check("mrst.ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mrst.no_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mrst.no_req", {31'd0, bus.mem_req}, 32'd0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
